// File: rtl/map_restore_loader.sv
// Restores the pristine maze into map_RAM port B from the map ROM, one row per
// ROM_LATENCY+1 cycles, counting pill tiles; otherwise passes map_RAM_writer through.
`timescale 1ns/1ps
module map_restore_loader #(
    parameter int         ROWS        = 30,
    parameter int         COLS        = 40,
    parameter int         ROM_LATENCY = 2,
    parameter logic [3:0] PILL_CODE   = 4'd2
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              start,
    output logic [4:0]        rom_addr,
    input  logic [4*COLS-1:0] rom_data,
    input  logic              wr_in_wren,
    input  logic [4:0]        wr_in_addr,
    input  logic [4*COLS-1:0] wr_in_data,
    output logic              wr_stall,
    output logic              ram_wren,
    output logic [4:0]        ram_addr,
    output logic [4*COLS-1:0] ram_data,
    output logic              busy,
    output logic              done,
    output logic [10:0]       pill_total
);
    localparam int                WAIT_W    = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ROM_LATENCY - 1);
    localparam logic [4:0]        LAST_ROW  = 5'(ROWS - 1);

    typedef enum logic [1:0] {IDLE, WAIT, WRITE, DONE} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [4:0]        r_row;
    logic [WAIT_W-1:0] r_wait;
    logic [10:0]       r_pill_total;
    logic [10:0]       w_row_pills;

    always_comb begin
        w_row_pills = '0;
        for (int unsigned i = 0; i < COLS; i++) begin
            if (rom_data[4*i +: 4] == PILL_CODE) begin
                w_row_pills = w_row_pills + 11'd1;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = WAIT;
            WAIT:    if (r_wait == WAIT_LAST) w_next = WRITE;
            WRITE:   w_next = (r_row == LAST_ROW) ? DONE : WAIT;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Row, latency counter and pill total advance alongside the state register.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_row        <= '0;
            r_wait       <= '0;
            r_pill_total <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_row        <= '0;
                        r_wait       <= '0;
                        r_pill_total <= '0;
                    end
                end
                WAIT: begin
                    r_wait <= r_wait + 1'b1;
                end
                WRITE: begin
                    r_pill_total <= r_pill_total + w_row_pills;
                    r_wait       <= '0;
                    if (r_row != LAST_ROW) begin
                        r_row <= r_row + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rom_addr   = r_row;
        pill_total = r_pill_total;
        busy       = (r_state != IDLE);
        done       = (r_state == DONE);
        if (r_state == IDLE) begin
            ram_wren = wr_in_wren;
            ram_addr = wr_in_addr;
            ram_data = wr_in_data;
            wr_stall = 1'b0;
        end else begin
            ram_wren = (r_state == WRITE);
            ram_addr = r_row;
            ram_data = rom_data;
            wr_stall = wr_in_wren;
        end
    end
endmodule

// File: tb/tb_map_restore_loader.sv
// Scoreboard bench for map_restore_loader: default instance with a 2-cycle ROM,
// second instance with a 1-cycle ROM holding an all-pill map.
`timescale 1ns/1ps
module tb_map_restore_loader;
    localparam int           W         = 160;
    localparam logic [W-1:0] ALL_PILLS = {40{4'h2}};

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, start, start1;
    logic         wr_in_wren;
    logic [4:0]   wr_in_addr;
    logic [W-1:0] wr_in_data;

    logic [4:0]   rom_addr0, ram_addr0, rom_addr1, ram_addr1;
    logic [W-1:0] rom_data0, ram_data0, rom_data1, ram_data1;
    logic         wr_stall0, ram_wren0, busy0, done0;
    logic         wr_stall1, ram_wren1, busy1, done1;
    logic [10:0]  pill_total0, pill_total1;

    map_restore_loader #(.ROWS(30), .COLS(40), .ROM_LATENCY(2), .PILL_CODE(4'd2)) dut (
        .CLOCK_50(clk), .reset(reset), .start(start),
        .rom_addr(rom_addr0), .rom_data(rom_data0),
        .wr_in_wren(wr_in_wren), .wr_in_addr(wr_in_addr), .wr_in_data(wr_in_data),
        .wr_stall(wr_stall0), .ram_wren(ram_wren0), .ram_addr(ram_addr0), .ram_data(ram_data0),
        .busy(busy0), .done(done0), .pill_total(pill_total0)
    );

    map_restore_loader #(.ROWS(30), .COLS(40), .ROM_LATENCY(1), .PILL_CODE(4'd2)) dut1 (
        .CLOCK_50(clk), .reset(reset), .start(start1),
        .rom_addr(rom_addr1), .rom_data(rom_data1),
        .wr_in_wren(wr_in_wren), .wr_in_addr(wr_in_addr), .wr_in_data(wr_in_data),
        .wr_stall(wr_stall1), .ram_wren(ram_wren1), .ram_addr(ram_addr1), .ram_data(ram_data1),
        .busy(busy1), .done(done1), .pill_total(pill_total1)
    );

    function automatic logic [W-1:0] row_word(input logic [4:0] r);
        logic [W-1:0] w;
        for (int i = 0; i < 40; i++) w[4*i +: 4] = r[3:0];
        return w;
    endfunction

    function automatic int count_pills(input logic [W-1:0] w);
        int n = 0;
        for (int i = 0; i < 40; i++) if (w[4*i +: 4] == 4'd2) n++;
        return n;
    endfunction

    // ROM models: two register stages for the default instance, one for the second.
    logic [4:0] p0a, p0b;
    always @(posedge clk) begin
        p0a <= rom_addr0;
        p0b <= p0a;
        rom_data1 <= (rom_addr1 < 5'd30) ? ALL_PILLS : '0;
    end
    assign rom_data0 = row_word(p0b);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int           n_checks = 0;
    int           n_pass   = 0;
    logic [164:0] exp_q[$];
    int           wr_count = 0;
    int           last_wr_cyc = 0;
    bit           have_last = 0;
    bit           mon_on = 0;
    int           exp_pills = 0;
    logic [W-1:0] pt;

    task automatic push_rows(input int n);
        wr_count  = 0;
        have_last = 0;
        for (int r = 0; r < n; r++) exp_q.push_back({5'(r), row_word(5'(r))});
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic run_until_done(input bit sel, input int budget, output int busy_cyc,
                                  output int done_cnt, output int done_cyc, output int writes);
        logic b, d, w;
        busy_cyc = 0; done_cnt = 0; done_cyc = -1; writes = 0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            b = sel ? busy1 : busy0;
            d = sel ? done1 : done0;
            w = sel ? ram_wren1 : ram_wren0;
            if (b && !d) busy_cyc++;
            if (b && w) writes++;
            if (d) begin done_cnt++; done_cyc = cyc; end
            if (done_cnt > 0 && !b) break;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        n_checks++; if (busy0 !== 1'b0) $display("FAIL reset_busy: got %b, required 0", busy0); else n_pass++;
        n_checks++; if (done0 !== 1'b0) $display("FAIL reset_done: got %b, required 0", done0); else n_pass++;
        n_checks++; if (wr_stall0 !== 1'b0) $display("FAIL reset_stall: got %b, required 0", wr_stall0); else n_pass++;
        n_checks++; if (pill_total0 !== 11'd0) $display("FAIL reset_pills: got %0d, required 0", pill_total0); else n_pass++;
        n_checks++; if (rom_addr0 !== 5'd0) $display("FAIL reset_rom_addr: got %0d, required 0", rom_addr0); else n_pass++;
        n_checks++; if (ram_wren0 !== 1'b0) $display("FAIL reset_ram_wren: got %b, required 0", ram_wren0); else n_pass++;
        n_checks++; if (busy1 !== 1'b0) $display("FAIL reset_busy1: got %b, required 0", busy1); else n_pass++;
    endtask

    task automatic test_passthrough();
        pt = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        @(posedge clk); #1;
        wr_in_wren = 1'b1; wr_in_addr = 5'd7; wr_in_data = pt;
        @(negedge clk);
        n_checks++; if (ram_wren0 !== 1'b1) $display("FAIL pt_wren: got %b, required 1", ram_wren0); else n_pass++;
        n_checks++; if (ram_addr0 !== 5'd7) $display("FAIL pt_addr: got %0d, required 7", ram_addr0); else n_pass++;
        n_checks++; if (ram_data0 !== pt) $display("FAIL pt_data: got %h, required %h", ram_data0, pt); else n_pass++;
        n_checks++; if (wr_stall0 !== 1'b0) $display("FAIL pt_stall: got %b, required 0", wr_stall0); else n_pass++;
        n_checks++; if (busy0 !== 1'b0) $display("FAIL pt_busy: got %b, required 0", busy0); else n_pass++;
        @(posedge clk); #1;
        wr_in_wren = 1'b0; wr_in_addr = 5'd21;
        @(negedge clk);
        n_checks++; if (ram_wren0 !== 1'b0) $display("FAIL pt_wren_low: got %b, required 0", ram_wren0); else n_pass++;
        n_checks++; if (ram_addr0 !== 5'd21) $display("FAIL pt_addr2: got %0d, required 21", ram_addr0); else n_pass++;
    endtask

    task automatic test_full_restore();
        int bc, dc, dcyc, wn;
        push_rows(30);
        mon_on = 1'b1;
        pulse_start();
        run_until_done(1'b0, 200, bc, dc, dcyc, wn);
        n_checks++; if (dc !== 1) $display("FAIL full_done_pulses: got %0d, required 1", dc); else n_pass++;
        n_checks++; if (bc !== 90) $display("FAIL full_busy_cycles: got %0d, required 90", bc); else n_pass++;
        n_checks++; if (wr_count !== 30) $display("FAIL full_writes: got %0d, required 30", wr_count); else n_pass++;
        n_checks++; if (exp_q.size() !== 0) $display("FAIL full_sb_left: got %0d, required 0", exp_q.size()); else n_pass++;
        n_checks++; if (dcyc !== last_wr_cyc + 1) $display("FAIL full_done_timing: got cycle %0d, required %0d", dcyc, last_wr_cyc + 1); else n_pass++;
        n_checks++; if (pill_total0 !== 11'(exp_pills)) $display("FAIL full_pills: got %0d, required %0d", pill_total0, exp_pills); else n_pass++;
        n_checks++; if (busy0 !== 1'b0) $display("FAIL full_busy_after: got %b, required 0", busy0); else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++; if (pill_total0 !== 11'(exp_pills)) $display("FAIL full_pills_hold: got %0d, required %0d", pill_total0, exp_pills); else n_pass++;
    endtask

    task automatic test_stall();
        int bc, dc, dcyc, wn;
        push_rows(30);
        pulse_start();
        repeat (20) @(negedge clk);
        @(posedge clk); #1;
        pt = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        wr_in_wren = 1'b1; wr_in_addr = 5'd5; wr_in_data = pt;
        @(negedge clk);
        n_checks++; if (wr_stall0 !== 1'b1) $display("FAIL stall_high: got %b, required 1", wr_stall0); else n_pass++;
        run_until_done(1'b0, 200, bc, dc, dcyc, wn);
        n_checks++; if (dc !== 1) $display("FAIL stall_done_pulses: got %0d, required 1", dc); else n_pass++;
        n_checks++; if (wr_count !== 30) $display("FAIL stall_writes: got %0d, required 30", wr_count); else n_pass++;
        n_checks++; if (exp_q.size() !== 0) $display("FAIL stall_sb_left: got %0d, required 0", exp_q.size()); else n_pass++;
        n_checks++; if (wr_stall0 !== 1'b0) $display("FAIL stall_release: got %b, required 0", wr_stall0); else n_pass++;
        n_checks++; if ({ram_wren0, ram_addr0} !== {1'b1, 5'd5}) $display("FAIL stall_pending_write: got wren %b addr %0d, required 1/5", ram_wren0, ram_addr0); else n_pass++;
        n_checks++; if (ram_data0 !== pt) $display("FAIL stall_pending_data: got %h, required %h", ram_data0, pt); else n_pass++;
        @(posedge clk); #1 wr_in_wren = 1'b0;
    endtask

    task automatic test_start_while_busy();
        int bc, dc, dcyc, wn;
        bit found = 0;
        push_rows(30);
        pulse_start();
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            if (rom_addr0 == 5'd10) found = 1;
        end
        n_checks++; if (found !== 1'b1) $display("FAIL busy_reach_row10: got %b, required 1", found); else n_pass++;
        pulse_start();
        run_until_done(1'b0, 200, bc, dc, dcyc, wn);
        n_checks++; if (dc !== 1) $display("FAIL busy_done_pulses: got %0d, required 1", dc); else n_pass++;
        n_checks++; if (wr_count !== 30) $display("FAIL busy_writes: got %0d, required 30", wr_count); else n_pass++;
        n_checks++; if (exp_q.size() !== 0) $display("FAIL busy_sb_left: got %0d, required 0", exp_q.size()); else n_pass++;
        n_checks++; if (pill_total0 !== 11'(exp_pills)) $display("FAIL busy_pills: got %0d, required %0d", pill_total0, exp_pills); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int bc, dc, dcyc, wn;
        bit found = 0;
        push_rows(15);
        pulse_start();
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            if (busy0 && rom_addr0 == 5'd15) found = 1;
        end
        n_checks++; if (found !== 1'b1) $display("FAIL mid_reach_row15: got %b, required 1", found); else n_pass++;
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        n_checks++; if (busy0 !== 1'b0) $display("FAIL mid_busy: got %b, required 0", busy0); else n_pass++;
        n_checks++; if (pill_total0 !== 11'd0) $display("FAIL mid_pills: got %0d, required 0", pill_total0); else n_pass++;
        repeat (5) @(negedge clk);
        n_checks++; if (wr_count !== 15) $display("FAIL mid_writes: got %0d, required 15", wr_count); else n_pass++;
        n_checks++; if (exp_q.size() !== 0) $display("FAIL mid_sb_left: got %0d, required 0", exp_q.size()); else n_pass++;
        push_rows(30);
        pulse_start();
        run_until_done(1'b0, 200, bc, dc, dcyc, wn);
        n_checks++; if (dc !== 1) $display("FAIL mid_redo_done: got %0d, required 1", dc); else n_pass++;
        n_checks++; if (wr_count !== 30) $display("FAIL mid_redo_writes: got %0d, required 30", wr_count); else n_pass++;
        n_checks++; if (pill_total0 !== 11'(exp_pills)) $display("FAIL mid_redo_pills: got %0d, required %0d", pill_total0, exp_pills); else n_pass++;
    endtask

    task automatic test_start_reset_same();
        int bc, dc, dcyc, wn;
        wr_count = 0;
        @(posedge clk); #1;
        start = 1'b1; start1 = 1'b1; reset = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; start1 = 1'b0; reset = 1'b0;
        @(negedge clk);
        n_checks++; if (busy0 !== 1'b0) $display("FAIL same_busy: got %b, required 0", busy0); else n_pass++;
        n_checks++; if (busy1 !== 1'b0) $display("FAIL same_busy1: got %b, required 0", busy1); else n_pass++;
        repeat (5) @(negedge clk);
        n_checks++; if (wr_count !== 0) $display("FAIL same_writes: got %0d, required 0", wr_count); else n_pass++;
        @(posedge clk); #1 start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        run_until_done(1'b1, 200, bc, dc, dcyc, wn);
        n_checks++; if (dc !== 1) $display("FAIL lat1_done_pulses: got %0d, required 1", dc); else n_pass++;
        n_checks++; if (bc !== 60) $display("FAIL lat1_busy_cycles: got %0d, required 60", bc); else n_pass++;
        n_checks++; if (wn !== 30) $display("FAIL lat1_writes: got %0d, required 30", wn); else n_pass++;
        n_checks++; if (pill_total1 !== 11'(30 * count_pills(ALL_PILLS))) $display("FAIL lat1_pills: got %0d, required %0d", pill_total1, 30 * count_pills(ALL_PILLS)); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; start1 = 1'b0;
        wr_in_wren = 1'b0; wr_in_addr = '0; wr_in_data = '0;
        for (int r = 0; r < 30; r++) exp_pills += count_pills(row_word(5'(r)));

        fork
            begin : monitor
                logic [164:0] e;
                forever begin
                    @(negedge clk);
                    if (mon_on && busy0 && ram_wren0) begin
                        n_checks++;
                        if (exp_q.size() == 0) begin
                            $display("FAIL sb_unexpected_write: got addr %0d, required no write", ram_addr0);
                        end else begin
                            e = exp_q.pop_front();
                            if ({ram_addr0, ram_data0} !== e)
                                $display("FAIL sb_write: got addr %0d data %h, required addr %0d data %h", ram_addr0, ram_data0, e[164:160], e[159:0]);
                            else n_pass++;
                        end
                        if (have_last) begin
                            n_checks++;
                            if (cyc - last_wr_cyc != 3) $display("FAIL sb_row_period: got %0d, required 3", cyc - last_wr_cyc);
                            else n_pass++;
                        end
                        have_last   = 1;
                        last_wr_cyc = cyc;
                        wr_count++;
                    end
                end
            end
        join_none

        test_reset();
        test_passthrough();
        test_full_restore();
        test_stall();
        test_start_while_busy();
        test_reset_mid();
        test_start_reset_same();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
